// File: rtl/m16sram_ctrl.sv
// Streams 16-lane rows between a sample stream and 16 parallel SRAM banks.
// Define M16SRAM_CTRL_BITREV_EN to bit-reverse the row address (FFT reordering).
module m16sram_ctrl #(
    parameter int AW = 12,
    parameter int DW = 64
) (
    input  logic          CLK,
    input  logic          RSTN,
    input  logic          START_LD,
    input  logic          START_RD,
    input  logic [AW:0]   LEN,
    output logic          BUSY,
    output logic          DONE,
    input  logic          IN_VALID,
    output logic          IN_READY,
    input  logic [DW-1:0] IN_DATA,
    output logic          OUT_VALID,
    input  logic          OUT_READY,
    output logic [DW-1:0] OUT_DATA,
    output logic          WE,
    output logic [AW-1:0] ADDR0, ADDR1, ADDR2, ADDR3, ADDR4, ADDR5, ADDR6, ADDR7,
    output logic [AW-1:0] ADDR8, ADDR9, ADDR10, ADDR11, ADDR12, ADDR13, ADDR14, ADDR15,
    output logic [DW-1:0] D0, D1, D2, D3, D4, D5, D6, D7,
    output logic [DW-1:0] D8, D9, D10, D11, D12, D13, D14, D15,
    input  logic [DW-1:0] Q0, Q1, Q2, Q3, Q4, Q5, Q6, Q7,
    input  logic [DW-1:0] Q8, Q9, Q10, Q11, Q12, Q13, Q14, Q15
);
    typedef enum logic [2:0] {IDLE, LOAD, WRITE, RD_ADDR, RD_OUT} state_t;

    state_t        state, state_nxt;
    logic [3:0]    lane_cnt;
    logic [AW:0]   row_cnt, row_nxt, len_r;
    logic [AW-1:0] row_addr, addr_hold, addr;
    logic [DW-1:0] lanes [16];
    logic [DW-1:0] q [16];
    logic          done_r, row_last;

    assign q = '{Q0, Q1, Q2, Q3, Q4, Q5, Q6, Q7, Q8, Q9, Q10, Q11, Q12, Q13, Q14, Q15};

    // row_cnt is one bit wider than the address so LEN=2^AW can terminate
    assign row_nxt  = row_cnt + 1'b1;
    assign row_last = (row_nxt == len_r);

`ifdef M16SRAM_CTRL_BITREV_EN
    always_comb begin
        row_addr = '0;
        for (int i = 0; i < AW; i++) row_addr[i] = row_cnt[AW-1-i];
    end
`else
    assign row_addr = row_cnt[AW-1:0];
`endif

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (START_LD)      state_nxt = (LEN != '0) ? LOAD : IDLE;
                else if (START_RD) state_nxt = (LEN != '0) ? RD_ADDR : IDLE;
            end
            LOAD:    if (IN_VALID && lane_cnt == 4'd15) state_nxt = WRITE;
            WRITE:   state_nxt = row_last ? IDLE : LOAD;
            RD_ADDR: state_nxt = RD_OUT;
            RD_OUT:  if (OUT_READY && lane_cnt == 4'd15) state_nxt = row_last ? IDLE : RD_ADDR;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        BUSY      = (state != IDLE);
        DONE      = done_r;
        IN_READY  = (state == LOAD);
        WE        = (state == WRITE);
        OUT_VALID = (state == RD_OUT);
        OUT_DATA  = (state == RD_OUT) ? q[lane_cnt] : '0;
        addr      = (state == WRITE || state == RD_ADDR) ? row_addr : addr_hold;
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            lane_cnt  <= '0;
            row_cnt   <= '0;
            len_r     <= '0;
            addr_hold <= '0;
            done_r    <= 1'b0;
            for (int i = 0; i < 16; i++) lanes[i] <= '0;
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE: if (START_LD || START_RD) begin
                    len_r    <= LEN;
                    row_cnt  <= '0;
                    lane_cnt <= '0;
                    done_r   <= (LEN == '0);
                end
                LOAD: if (IN_VALID) begin
                    lanes[lane_cnt] <= IN_DATA;
                    lane_cnt        <= lane_cnt + 4'd1;
                end
                WRITE: begin
                    addr_hold <= row_addr;
                    row_cnt   <= row_nxt;
                    done_r    <= row_last;
                end
                RD_ADDR: addr_hold <= row_addr;
                RD_OUT: if (OUT_READY) begin
                    lane_cnt <= lane_cnt + 4'd1;
                    if (lane_cnt == 4'd15) begin
                        row_cnt <= row_nxt;
                        done_r  <= row_last;
                    end
                end
                default: ;
            endcase
        end
    end

    assign {ADDR0, ADDR1, ADDR2, ADDR3, ADDR4, ADDR5, ADDR6, ADDR7}       = {8{addr}};
    assign {ADDR8, ADDR9, ADDR10, ADDR11, ADDR12, ADDR13, ADDR14, ADDR15} = {8{addr}};
    assign {D0, D1, D2, D3, D4, D5, D6, D7} =
        {lanes[0], lanes[1], lanes[2], lanes[3], lanes[4], lanes[5], lanes[6], lanes[7]};
    assign {D8, D9, D10, D11, D12, D13, D14, D15} =
        {lanes[8], lanes[9], lanes[10], lanes[11], lanes[12], lanes[13], lanes[14], lanes[15]};
endmodule

// File: tb/tb_m16sram_ctrl.sv
// Directed bench for m16sram_ctrl with a behavioural 16-bank SRAM model.
module tb_m16sram_ctrl;
    localparam int AW = 12;
    localparam int DW = 64;
`ifdef M16SRAM_CTRL_BITREV_EN
    localparam logic [AW-1:0] ROW1 = 12'h800;
`else
    localparam logic [AW-1:0] ROW1 = 12'h001;
`endif

    logic          CLK = 0, RSTN = 0, START_LD = 0, START_RD = 0, IN_VALID = 0, OUT_READY = 0;
    logic [AW:0]   LEN = '0;
    logic [DW-1:0] IN_DATA = '0;
    logic          BUSY, DONE, IN_READY, OUT_VALID, WE;
    logic [DW-1:0] OUT_DATA;
    logic [AW-1:0] addr [16];
    logic [DW-1:0] d [16];
    logic [DW-1:0] q [16];
    logic [DW-1:0] mem [16][1<<AW];

    typedef logic [15:0][DW-1:0] row_t;
    row_t          we_d [$];
    logic [AW-1:0] we_a [$];
    int            we_c [$];
    row_t          mon_row;
    bit            addr_split = 0, overlap = 0;
    int            cyc = 0, total = 0, bad = 0;

    m16sram_ctrl #(.AW(AW), .DW(DW)) dut (
        .CLK(CLK), .RSTN(RSTN), .START_LD(START_LD), .START_RD(START_RD), .LEN(LEN),
        .BUSY(BUSY), .DONE(DONE), .IN_VALID(IN_VALID), .IN_READY(IN_READY), .IN_DATA(IN_DATA),
        .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .OUT_DATA(OUT_DATA), .WE(WE),
        .ADDR0(addr[0]), .ADDR1(addr[1]), .ADDR2(addr[2]), .ADDR3(addr[3]),
        .ADDR4(addr[4]), .ADDR5(addr[5]), .ADDR6(addr[6]), .ADDR7(addr[7]),
        .ADDR8(addr[8]), .ADDR9(addr[9]), .ADDR10(addr[10]), .ADDR11(addr[11]),
        .ADDR12(addr[12]), .ADDR13(addr[13]), .ADDR14(addr[14]), .ADDR15(addr[15]),
        .D0(d[0]), .D1(d[1]), .D2(d[2]), .D3(d[3]), .D4(d[4]), .D5(d[5]), .D6(d[6]), .D7(d[7]),
        .D8(d[8]), .D9(d[9]), .D10(d[10]), .D11(d[11]), .D12(d[12]), .D13(d[13]), .D14(d[14]), .D15(d[15]),
        .Q0(q[0]), .Q1(q[1]), .Q2(q[2]), .Q3(q[3]), .Q4(q[4]), .Q5(q[5]), .Q6(q[6]), .Q7(q[7]),
        .Q8(q[8]), .Q9(q[9]), .Q10(q[10]), .Q11(q[11]), .Q12(q[12]), .Q13(q[13]), .Q14(q[14]), .Q15(q[15])
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) begin
        cyc <= cyc + 1;
        for (int i = 0; i < 16; i++) begin
            if (WE) mem[i][addr[i]] <= d[i];
            else    q[i] <= mem[i][addr[i]];
        end
    end

    always @(negedge CLK) begin
        if (WE) begin
            for (int i = 0; i < 16; i++) begin
                mon_row[i] = d[i];
                if (addr[i] !== addr[0]) addr_split = 1;
            end
            we_a.push_back(addr[0]);
            we_d.push_back(mon_row);
            we_c.push_back(cyc);
        end
        if (DONE && BUSY) overlap = 1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    task automatic start(input bit ld, input bit rd, input int len);
        START_LD = ld; START_RD = rd; LEN = len[AW:0];
        @(negedge CLK);
        START_LD = 0; START_RD = 0;
    endtask

    task automatic push(input logic [DW-1:0] v);
        int t = 0;
        IN_VALID = 1; IN_DATA = v;
        while (!IN_READY && t < 50) begin @(negedge CLK); t++; end
        if (t >= 50) begin total++; bad++; $display("FAIL push_timeout got=0 exp=1"); end
        @(negedge CLK);
        IN_VALID = 0;
    endtask

    task automatic wait_done(output int dc);
        int t = 0;
        while (!DONE && t < 100) begin @(negedge CLK); t++; end
        dc = cyc;
        total++;
        if (DONE !== 1'b1) begin bad++; $display("FAIL done_timeout got=%b exp=1", DONE); end
    endtask

    task automatic test_reset;
        RSTN = 0;
        repeat (2) @(negedge CLK);
        for (int p = 0; p < 2; p++) begin
            total++;
            if ({BUSY, DONE, WE, IN_READY, OUT_VALID} !== 5'b0 || OUT_DATA !== '0 ||
                addr[0] !== '0 || addr[15] !== '0 || d[0] !== '0 || d[15] !== '0) begin
                bad++;
                $display("FAIL reset_state phase=%0d got=%b%b%b%b%b data=%0h addr=%0h d0=%0h exp=all zero",
                         p, BUSY, DONE, WE, IN_READY, OUT_VALID, OUT_DATA, addr[0], d[0]);
            end
            RSTN = 1;
            @(negedge CLK);
        end
    endtask

    task automatic test_load;
        int n0 = we_a.size(), dc;
        start(1, 0, 2);
        for (int k = 0; k < 32; k++) push(k);
        wait_done(dc);
        total++;
        if (we_a.size() != n0 + 2) begin
            bad++; $display("FAIL load_we_count got=%0d exp=2", we_a.size() - n0);
        end else begin
            total += 4;
            if (we_a[n0] !== 0)    begin bad++; $display("FAIL load_addr0 got=%0h exp=0", we_a[n0]); end
            if (we_a[n0+1] !== ROW1) begin bad++; $display("FAIL load_addr1 got=%0h exp=%0h", we_a[n0+1], ROW1); end
            if (dc != we_c[n0+1] + 1) begin bad++; $display("FAIL load_done_cycle got=%0d exp=%0d", dc, we_c[n0+1] + 1); end
            if (we_c[n0+1] - we_c[n0] != 17) begin bad++; $display("FAIL load_we_spacing got=%0d exp=17", we_c[n0+1] - we_c[n0]); end
            for (int i = 0; i < 16; i++) begin
                total += 2;
                if (we_d[n0][i] !== DW'(i)) begin bad++; $display("FAIL load_row0_d%0d got=%0h exp=%0h", i, we_d[n0][i], i); end
                if (we_d[n0+1][i] !== DW'(16 + i)) begin bad++; $display("FAIL load_row1_d%0d got=%0h exp=%0h", i, we_d[n0+1][i], 16 + i); end
            end
        end
        total++;
        if (addr_split) begin bad++; $display("FAIL load_addr_equal got=split exp=equal"); end
    endtask

    task automatic test_read;
        logic [DW-1:0] bd [$];
        int bc [$];
        int dc = -1;
        start(0, 1, 2);
        OUT_READY = 1;
        for (int t = 0; t < 100; t++) begin
            if (DONE) begin dc = cyc; break; end
            if (OUT_VALID) begin bd.push_back(OUT_DATA); bc.push_back(cyc); end
            @(negedge CLK);
        end
        OUT_READY = 0;
        total++;
        if (bd.size() != 32) begin
            bad++; $display("FAIL read_beats got=%0d exp=32", bd.size());
        end else begin
            for (int k = 0; k < 32; k++) begin
                total++;
                if (bd[k] !== DW'(k)) begin bad++; $display("FAIL read_data%0d got=%0h exp=%0h", k, bd[k], k); end
            end
            total += 3;
            if (bc[15] - bc[0] != 15) begin bad++; $display("FAIL read_row0_span got=%0d exp=15", bc[15] - bc[0]); end
            if (bc[16] - bc[15] != 2) begin bad++; $display("FAIL read_row_gap got=%0d exp=2", bc[16] - bc[15]); end
            if (dc != bc[31] + 1) begin bad++; $display("FAIL read_done_cycle got=%0d exp=%0d", dc, bc[31] + 1); end
        end
    endtask

    task automatic test_stall;
        bit pat [4] = '{1, 0, 0, 1};
        logic [DW-1:0] bd [$];
        logic [DW-1:0] prevd = '0;
        bit prev_stall = 0;
        int c = 0;
        start(0, 1, 1);
        for (int t = 0; t < 200; t++) begin
            if (DONE) break;
            OUT_READY = pat[c % 4];
            c++;
            if (prev_stall) begin
                total++;
                if (!OUT_VALID || OUT_DATA !== prevd) begin
                    bad++; $display("FAIL stall_hold got=%b/%0h exp=1/%0h", OUT_VALID, OUT_DATA, prevd);
                end
            end
            if (OUT_VALID) begin
                total++;
                if (addr[0] !== '0) begin bad++; $display("FAIL stall_addr got=%0h exp=0", addr[0]); end
                if (OUT_READY) bd.push_back(OUT_DATA);
                prev_stall = !OUT_READY;
                prevd = OUT_DATA;
            end else prev_stall = 0;
            @(negedge CLK);
        end
        OUT_READY = 0;
        total++;
        if (bd.size() != 16) begin
            bad++; $display("FAIL stall_beats got=%0d exp=16", bd.size());
        end else for (int k = 0; k < 16; k++) begin
            total++;
            if (bd[k] !== DW'(k)) begin bad++; $display("FAIL stall_data%0d got=%0h exp=%0h", k, bd[k], k); end
        end
    endtask

    task automatic test_len0;
        int n0 = we_a.size();
        for (int r = 0; r < 2; r++) begin
            start(r == 0, r == 1, 0);
            total++;
            if ({DONE, BUSY, IN_READY, OUT_VALID} !== 4'b1000) begin
                bad++; $display("FAIL len0_pulse cmd=%0d got=%b exp=1000", r, {DONE, BUSY, IN_READY, OUT_VALID});
            end
            @(negedge CLK);
            total++;
            if ({DONE, BUSY} !== 2'b00) begin bad++; $display("FAIL len0_after cmd=%0d got=%b exp=00", r, {DONE, BUSY}); end
        end
        total++;
        if (we_a.size() != n0) begin bad++; $display("FAIL len0_no_we got=%0d exp=0", we_a.size() - n0); end
    endtask

    task automatic test_both;
        int n0 = we_a.size(), dc;
        start(1, 1, 1);
        total++;
        if ({IN_READY, OUT_VALID, BUSY} !== 3'b101) begin
            bad++; $display("FAIL both_load_wins got=%b exp=101", {IN_READY, OUT_VALID, BUSY});
        end
        for (int i = 0; i < 16; i++) push(200 + i);
        wait_done(dc);
        total++;
        if (we_a.size() != n0 + 1 || we_d[$][0] !== 200 || we_d[$][15] !== 215) begin
            bad++; $display("FAIL both_write got=%0d/%0h/%0h exp=1/c8/d7", we_a.size() - n0, we_d[$][0], we_d[$][15]);
        end
    endtask

    task automatic test_busy_ignore;
        int n0 = we_a.size(), dc, seen = 0;
        start(1, 0, 1);
        for (int i = 0; i < 3; i++) push(300 + i);
        START_RD = 1; LEN = 1;
        push(303);
        START_RD = 0;
        for (int i = 4; i < 16; i++) push(300 + i);
        wait_done(dc);
        total++;
        if (we_a.size() != n0 + 1 || we_d[$][3] !== 303 || we_d[$][4] !== 304) begin
            bad++; $display("FAIL busy_load got=%0d/%0h/%0h exp=1/12f/130", we_a.size() - n0, we_d[$][3], we_d[$][4]);
        end
        for (int t = 0; t < 6; t++) begin @(negedge CLK); if (OUT_VALID || BUSY) seen++; end
        total++;
        if (seen != 0) begin bad++; $display("FAIL busy_rd_ignored got=%0d exp=0", seen); end
    endtask

    task automatic test_abort;
        int n0, npre = we_a.size(), dc;
        start(1, 0, 1);
        for (int i = 0; i < 7; i++) push(400 + i);
        RSTN = 0;
        #1;
        total++;
        if ({BUSY, IN_READY, WE, DONE} !== 4'b0 || d[0] !== '0 || d[6] !== '0) begin
            bad++; $display("FAIL abort_reset got=%b d0=%0h d6=%0h exp=0000/0/0", {BUSY, IN_READY, WE, DONE}, d[0], d[6]);
        end
        @(negedge CLK);
        RSTN = 1;
        @(negedge CLK);
        n0 = we_a.size();
        total++;
        if (n0 != npre) begin bad++; $display("FAIL abort_no_we got=%0d exp=0", n0 - npre); end
        start(1, 0, 1);
        for (int i = 0; i < 16; i++) push(500 + i);
        wait_done(dc);
        total++;
        if (we_a.size() != n0 + 1 || we_a[$] !== '0 || we_d[$][0] !== 500 ||
            we_d[$][6] !== 506 || we_d[$][15] !== 515) begin
            bad++; $display("FAIL abort_reload got=%0d a=%0h d0=%0h d6=%0h d15=%0h exp=1/0/1f4/1fa/203",
                            we_a.size() - n0, we_a[$], we_d[$][0], we_d[$][6], we_d[$][15]);
        end
    endtask

    initial begin
        test_reset();
        test_load();
        test_read();
        test_stall();
        test_len0();
        test_both();
        test_busy_ignore();
        test_abort();
        total++;
        if (overlap || addr_split) begin bad++; $display("FAIL global_flags got=%b%b exp=00", overlap, addr_split); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
